// File: rtl/wide_add_pkg.sv
// Shared definitions for the sequential wide adder.
// Holds the FSM state type, the default slice width and slice count, and the
// helper that sizes the slice index register.
package wide_add_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAdd,
        StDone
    } state_e;

    localparam int unsigned DefaultN     = 7;
    localparam int unsigned DefaultWords = 4;

    // ceil(log2(words)), with a floor of one bit so the index always exists.
    function automatic int unsigned idx_width(input int unsigned words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/wide_add_seq_rca.sv
// N-bit ripple-carry adder slice.
// Ports:
//   a_i, b_i   : slice operands
//   cin_i      : carry in
//   sum_o      : slice sum
//   cout_o     : carry out of the top bit
module wide_add_seq_rca #(
    parameter int unsigned W = 7
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);

    always_comb begin
        logic c;
        c     = cin_i;
        sum_o = '0;
        for (int i = 0; i < int'(W); i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ c;
            c        = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
        end
        cout_o = c;
    end

endmodule

// File: rtl/wide_add_seq.sv
// Sequential wide adder: adds two N*WORDS-bit operands one N-bit slice per
// cycle through a single shared ripple-carry slice, LSB slice first.
// Optional feature: define WIDE_ADD_SEQ_OVF_EN to build the signed overflow
// flag; otherwise ovf is tied low.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : operand handshake (a, b, cin)
//   out_valid / out_ready: result handshake (sum, cout, ovf)
//   busy                 : high while adding or holding a result
module wide_add_seq
    import wide_add_pkg::*;
#(
    parameter int unsigned N     = DefaultN,
    parameter int unsigned WORDS = DefaultWords
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*WORDS-1:0] a,
    input  logic [N*WORDS-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N*WORDS-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned W    = N * WORDS;
    localparam int unsigned IdxW = idx_width(WORDS);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

    state_e          state_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    sum_q;
    logic [IdxW-1:0] idx_q;
    logic            carry_q;
    logic            cout_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            busy_q;

    logic [N-1:0]    slice_a;
    logic [N-1:0]    slice_b;
    logic [N-1:0]    slice_sum;
    logic            slice_cout;

    always_comb begin
        slice_a = a_q[int'(idx_q) * N +: N];
        slice_b = b_q[int'(idx_q) * N +: N];
    end

    // The only adder in the design; the FSM time-multiplexes it over slices.
    wide_add_seq_rca #(
        .W (N)
    ) u_rca (
        .a_i    (slice_a),
        .b_i    (slice_b),
        .cin_i  (carry_q),
        .sum_o  (slice_sum),
        .cout_o (slice_cout)
    );

`ifdef WIDE_ADD_SEQ_OVF_EN
    logic ovf_q;
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef WIDE_ADD_SEQ_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        carry_q    <= cin;
                        idx_q      <= '0;
                        sum_q      <= '0;
                        cout_q     <= 1'b0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
`ifdef WIDE_ADD_SEQ_OVF_EN
                        ovf_q      <= 1'b0;
`endif
                        state_q    <= StAdd;
                    end
                end
                StAdd: begin
                    sum_q[int'(idx_q) * N +: N] <= slice_sum;
                    carry_q <= slice_cout;
                    if (idx_q == LastIdx) begin
                        // Index stops at the last slice; it never wraps.
                        cout_q  <= slice_cout;
                        state_q <= StDone;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                StDone: begin
                    // First DONE cycle finalises flags from the complete sum,
                    // so out_valid appears WORDS+1 cycles after acceptance.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
`ifdef WIDE_ADD_SEQ_OVF_EN
                        ovf_q <= (a_q[W-1] == b_q[W-1]) && (sum_q[W-1] != a_q[W-1]);
`endif
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Self-checking bench for wide_add_seq (N=7, WORDS=4).
module tb_wide_add_seq;

    localparam int N     = 7;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    exp_t sb[$];
    int   n_checks;
    int   n_errs;

    wide_add_seq #(
        .N     (N),
        .WORDS (WORDS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_in),
        .b         (b_in),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic mc);
        exp_t         e;
        logic [W:0]   t;
        t      = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
        e.sum  = t[W-1:0];
        e.cout = t[W];
`ifdef WIDE_ADD_SEQ_OVF_EN
        e.ovf  = (ma[W-1] == mb[W-1]) && (t[W-1] != ma[W-1]);
`else
        e.ovf  = 1'b0;
`endif
        return e;
    endfunction

    // Presents one operand set, records the expectation, and waits (bounded)
    // for out_valid. lat is cycles from the accepting edge, or -1 on timeout.
    task automatic drive_and_wait(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                  input logic tc, input logic hold_ready, output int lat);
        int cnt;
        @(negedge clk);
        a_in      = ta;
        b_in      = tb;
        cin       = tc;
        in_valid  = 1'b1;
        out_ready = hold_ready;
        sb.push_back(model(ta, tb, tc));
        lat = -1;
        cnt = 0;
        while (lat < 0 && cnt < 20) begin
            @(negedge clk);
            cnt++;
            in_valid = 1'b0;
            if (out_valid === 1'b1) lat = cnt - 1;
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = '0;
        b_in      = '0;
        cin       = 1'b0;
        #12;
        n_checks++;
        if ({in_ready, out_valid, busy, cout, ovf} !== 5'b10000 || sum !== '0)
            $display("FAIL reset_state: got rdy=%b vld=%b busy=%b cout=%b ovf=%b sum=%h, want 1 0 0 0 0 0",
                     in_ready, out_valid, busy, cout, ovf, sum);
        if ({in_ready, out_valid, busy, cout, ovf} !== 5'b10000 || sum !== '0) n_errs++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add();
        logic [W-1:0] va[7];
        logic [W-1:0] vb[7];
        logic         vc[7];
        exp_t         e;
        int           lat;
        va[0] = 28'h0FFFFFF; vb[0] = 28'h0000001; vc[0] = 1'b0;
        va[1] = 28'hFFFFFFF; vb[1] = 28'h0000001; vc[1] = 1'b0;
        va[2] = 28'h0000000; vb[2] = 28'h0000000; vc[2] = 1'b1;
        for (int i = 3; i < 7; i++) begin
            va[i] = W'($urandom());
            vb[i] = W'($urandom());
            vc[i] = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_errs++;
                $display("FAIL add_idle_ready[%0d]: got %b want 1", i, in_ready);
            end
            // Odd vectors hold out_ready high through ADD; it must not matter.
            drive_and_wait(va[i], vb[i], vc[i], 1'(i % 2), lat);
            n_checks++;
            if (lat != WORDS + 1) begin
                n_errs++;
                $display("FAIL add_latency[%0d]: got %0d want %0d", i, lat, WORDS + 1);
            end
            e = sb.pop_front();
            n_checks++;
            if (sum !== e.sum || cout !== e.cout) begin
                n_errs++;
                $display("FAIL add_result[%0d]: got sum=%h cout=%b want sum=%h cout=%b",
                         i, sum, cout, e.sum, e.cout);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
                n_errs++;
                $display("FAIL add_return_idle[%0d]: got vld=%b rdy=%b busy=%b want 0 1 0",
                         i, out_valid, in_ready, busy);
            end
        end
    endtask

    task automatic test_ovf();
        exp_t e;
        int   lat;
        drive_and_wait(28'h7FFFFFF, 28'h0000001, 1'b0, 1'b0, lat);
        e = sb.pop_front();
        n_checks++;
        if (lat != WORDS + 1 || sum !== 28'h8000000 || ovf !== e.ovf) begin
            n_errs++;
            $display("FAIL ovf: got lat=%0d sum=%h ovf=%b want lat=%0d sum=8000000 ovf=%b",
                     lat, sum, ovf, WORDS + 1, e.ovf);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   lat;
        drive_and_wait(28'h8123456, 28'h9876543, 1'b1, 1'b0, lat);
        e = sb.pop_front();
        n_checks++;
        if (lat != WORDS + 1 || sum !== e.sum || cout !== e.cout || ovf !== e.ovf) begin
            n_errs++;
            $display("FAIL bp_result: got lat=%0d sum=%h cout=%b ovf=%b want %0d %h %b %b",
                     lat, sum, cout, ovf, WORDS + 1, e.sum, e.cout, e.ovf);
        end
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            a_in     = W'($urandom());
            b_in     = W'($urandom());
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== e.sum || cout !== e.cout
                || ovf !== e.ovf) begin
                n_errs++;
                $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b sum=%h cout=%b ovf=%b want 1 0 %h %b %b",
                         i, out_valid, in_ready, sum, cout, ovf, e.sum, e.cout, e.ovf);
            end
        end
        // Release with in_valid still high: must return to IDLE, not accept.
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_errs++;
            $display("FAIL bp_release: got vld=%b rdy=%b busy=%b want 0 1 0",
                     out_valid, in_ready, busy);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            n_errs++;
            $display("FAIL bp_no_accept: got busy=%b rdy=%b want 0 1", busy, in_ready);
        end
    endtask

    task automatic test_reset_abort();
        logic seen;
        @(negedge clk);
        a_in     = 28'h1234567;
        b_in     = 28'h0ABCDEF;
        cin      = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);  // accepted; now in first ADD cycle
        in_valid = 1'b0;
        @(negedge clk);  // second ADD cycle
        n_checks++;
        if (busy !== 1'b1) begin
            n_errs++;
            $display("FAIL abort_busy_before: got %b want 1", busy);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({in_ready, out_valid, busy, cout, ovf} !== 5'b10000 || sum !== '0) begin
            n_errs++;
            $display("FAIL abort_reset: got rdy=%b vld=%b busy=%b cout=%b ovf=%b sum=%h want 1 0 0 0 0 0",
                     in_ready, out_valid, busy, cout, ovf, sum);
        end
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_errs++;
            $display("FAIL abort_no_result: got activity=%b want 0", seen);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errs   = 0;
        test_reset();
        test_add();
        test_ovf();
        test_backpressure();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/wide_add_seq.md
WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

Interface
REQ-001 Parameter N, default 7: adder slice width in bits.
REQ-002 Parameter WORDS, default 4: number of N-bit slices per operand; legal range 2..16.
REQ-003 clk  input  1  clock; all state is updated on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  operand request.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a, b  input  N*WORDS each  operands.
REQ-008 cin  input  1  carry into the least-significant slice.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 sum  output  N*WORDS  registered result.
REQ-012 cout  output  1  carry out of the most-significant slice.
REQ-013 ovf  output  1  signed overflow flag; see Configuration.
REQ-014 busy  output  1  high in ADD and DONE.

Function
REQ-015 States SHALL be IDLE, ADD and DONE.
REQ-016 IDLE: in_ready=1; on in_valid&in_ready, capture a, b and cin into internal registers, clear the slice index, and go to ADD.
REQ-017 ADD: each cycle, add one N-bit slice at the current index (LSB slice first) plus the carry register; write the result slice into sum; update the carry register; increment the index.
REQ-018 The add SHALL use a single shared N-bit ripple-carry slice, i.e. exactly one N-bit adder in the design.
REQ-019 ADD SHALL last exactly WORDS cycles; after the last slice, go to DONE with cout equal to the final carry.
REQ-020 DONE: out_valid=1; sum, cout and ovf held stable; on out_ready, go to IDLE.
REQ-021 Latency: out_valid SHALL rise exactly WORDS+1 cycles after the accepting edge.
REQ-022 in_ready SHALL be 0 in ADD and DONE; in_valid is ignored there, with no queuing.
REQ-023 Backpressure: while out_ready is low, DONE is held indefinitely with no output change.
REQ-024 out_ready while not in DONE SHALL have no effect.
REQ-025 Simultaneous out_ready and in_valid in DONE: return to IDLE first; the new operands are accepted no earlier than the next cycle.
REQ-026 The slice index SHALL be ceil(log2(WORDS)) bits wide and SHALL never wrap within a transaction.

Reset
REQ-027 rst SHALL asynchronously force IDLE, index=0, carry register=0, sum=0, cout=0, ovf=0, out_valid=0, busy=0, in_ready=1.
REQ-028 Reset during ADD or DONE SHALL abort the transaction; no result is presented after reset release.

Configuration
REQ-029 Macro WIDE_ADD_SEQ_OVF_EN compiles the overflow logic in or out.
REQ-030 With WIDE_ADD_SEQ_OVF_EN defined: in DONE, ovf = (a_msb==b_msb) && (sum_msb!=a_msb), computed on the captured operands.
REQ-031 Without WIDE_ADD_SEQ_OVF_EN: the ovf port remains and is tied to 0; no overflow logic is synthesised.

Structure
REQ-032 Shared package wide_add_pkg SHALL hold the state enum (IDLE/ADD/DONE), the default N and WORDS, and the index-width constant function.
REQ-033 One sub-module: the existing N-bit RCA, instantiated once as the shared slice adder; all sequencing logic stays in wide_add_seq.

Verification (N=7, WORDS=4, 28-bit operands)
REQ-034 a=0x0FFFFFF, b=0x0000001, cin=0 -> sum=0x1000000, cout=0, out_valid 5 cycles after acceptance.
REQ-035 a=0xFFFFFFF, b=0x0000001, cin=0 -> sum=0x0000000, cout=1; carry ripples across all 4 slices.
REQ-036 a=0, b=0, cin=1 -> sum=0x0000001, cout=0.
REQ-037 out_ready held low 6 cycles in DONE -> sum, cout and ovf stable; in_ready=0 and in_valid ignored throughout; out_ready=1 -> IDLE next cycle.
REQ-038 rst pulsed in the 2nd ADD cycle -> all outputs 0, in_ready=1 immediately; no out_valid afterward.
REQ-039 a=0x7FFFFFF, b=0x0000001 -> ovf=1 with WIDE_ADD_SEQ_OVF_EN; ovf=0 without it; sum=0x8000000 in both builds.
